// File: rtl/multiword_add_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multiword_add_seq : W = N*WORDS bit adder on one shared N-bit slice
//   processing one word per clock, LS word first.    Rev 1.0
// ----------------------------------------------------------------------------
module multiword_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;
  logic [N:0]         slice_sum;

  // Full N+1-bit result so the slice carry is never truncated
  assign slice_sum = {1'b0, op_a_q[idx_q*N +: N]}
                   + {1'b0, op_b_q[idx_q*N +: N]}
                   + {{N{1'b0}}, carry_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = slice_sum[N-1:0];
        carry_d             = slice_sum[N];
        if (idx_q == LAST_IDX) begin
          // Top-word carry leaves via cout only; it never wraps into word 0
          cout_d      = slice_sum[N];
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multiword_add_seq : directed + random checks of multiword_add_seq
//   against a plain a+b+cin reference.    Rev 1.0
// ----------------------------------------------------------------------------
module tb_multiword_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid; returns number of edges taken (0 if bound expired)
  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  // Offer one pair in IDLE; returns after the accepting edge
  task automatic offer(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk("in_ready_before_accept", {32'd0, in_ready}, 33'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_drain_in_ready", {32'd0, in_ready}, 33'd1);
    chk("idle_after_drain_out_valid", {32'd0, out_valid}, 33'd0);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           edges;
    int           acc_cyc;
    int           prev_acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #2;
    chk("reset_sum", {1'b0, sum}, 33'd0);
    chk("reset_cout", {32'd0, cout}, 33'd0);
    chk("reset_out_valid", {32'd0, out_valid}, 33'd0);
    chk("reset_in_ready", {32'd0, in_ready}, 33'd1);
    chk("reset_busy", {32'd0, busy}, 33'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Carry ripple across word boundary
    offer(32'h000000FF, 32'h00000001, 1'b0);
    chk("ripple_busy", {32'd0, busy}, 33'd1);
    wait_valid(edges);
    chk("ripple_latency", 33'(edges), 33'(WORDS));
    chk("ripple_result", {cout, sum}, {1'b0, 32'h00000100});
    drain();

    // Full wrap into cout
    offer(32'hFFFFFFFF, 32'h0, 1'b1);
    wait_valid(edges);
    chk("wrap_latency", 33'(edges), 33'(WORDS));
    chk("wrap_result", {cout, sum}, {1'b1, 32'h00000000});

    // Backpressure: hold DONE with in_valid pulsing new data
    exp = {1'b1, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom);
      in_valid = ~in_valid;
      step();
      chk("bp_out_valid", {32'd0, out_valid}, 33'd1);
      chk("bp_result", {cout, sum}, exp);
      chk("bp_in_ready", {32'd0, in_ready}, 33'd0);
    end
    in_valid = 1'b0;
    drain();
    chk("bp_busy_after", {32'd0, busy}, 33'd0);

    // Reset while RUN at idx==2
    offer(32'h11111111, 32'h22222222, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sum", {1'b0, sum}, 33'd0);
    chk("rst_mid_cout", {32'd0, cout}, 33'd0);
    chk("rst_mid_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_mid_in_ready", {32'd0, in_ready}, 33'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    offer(32'd1, 32'd2, 1'b0);
    wait_valid(edges);
    chk("post_rst_result", {cout, sum}, 33'd3);
    drain();

    // Back-to-back with in_valid held high and out_ready=1
    out_ready = 1'b1;
    prev_acc  = 0;
    ra = $urandom; rb = $urandom; rc = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      a = ra; b = rb; cin = rc; in_valid = 1'b1;
      exp = ref_add(ra, rb, rc);
      chk("b2b_in_ready", {32'd0, in_ready}, 33'd1);
      step();
      acc_cyc = cyc;
      if (k > 0) chk("b2b_interval", 33'(acc_cyc - prev_acc), 33'(WORDS + 2));
      prev_acc = acc_cyc;
      a = $urandom; b = $urandom; cin = 1'($urandom);
      wait_valid(edges);
      chk("b2b_latency", 33'(edges), 33'(WORDS));
      chk("b2b_result", {cout, sum}, exp);
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    // Operand change after accept has no effect
    offer(32'd10, 32'd20, 1'b0);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
    wait_valid(edges);
    chk("late_change_result", {cout, sum}, 33'd30);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
